// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the RV32I multicycle datapath: opcode decode, per-state datapath
// controls, immediate-type select and a req/ready handshake with timeout to shared memory.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXECR  = 4'd7,
        EXECI  = 4'd8,
        ALUWB  = 4'd9,
        BRANCH = 4'd10,
        JAL    = 4'd11,
        JALR   = 4'd12,
        UPPER  = 4'd13,
        TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       retire;
        logic       trap;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur;
    state_t     nxt;
    ctrl_t      ctrl_q;
    logic [7:0] wait_cnt;

    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return MEMADR;
            OP_RTYPE:          return EXECR;
            OP_ITYPE:          return EXECI;
            OP_BR:             return BRANCH;
            OP_JAL:            return JAL;
            OP_JALR:           return JALR;
            OP_LUI, OP_AUIPC:  return UPPER;
            default:           return TRAP;
        endcase
    endfunction

    // A pending access either completes, gives up at the timeout, or keeps waiting.
    function automatic state_t mem_step(input state_t s, input logic ready,
                                        input logic [7:0] cnt, input state_t done);
        if (ready)
            return done;
        else if (cnt == WAIT_LAST)
            return TRAP;
        else
            return s;
    endfunction

    function automatic state_t next_state(input state_t s, input logic go, input logic [6:0] op,
                                          input logic ready, input logic [7:0] cnt);
        state_t boundary;
        boundary = go ? FETCH : IDLE;
        case (s)
            IDLE:                 return go ? FETCH : IDLE;
            FETCH:                return mem_step(s, ready, cnt, DECODE);
            DECODE:               return decode_target(op);
            MEMADR:               return (op == OP_STORE) ? MEMWR : MEMRD;
            MEMRD:                return mem_step(s, ready, cnt, MEMWB);
            MEMWR:                return mem_step(s, ready, cnt, boundary);
            MEMWB, ALUWB, BRANCH: return boundary;
            EXECR, EXECI, UPPER:  return ALUWB;
            JALR:                 return JAL;
            JAL:                  return ALUWB;
            default:              return TRAP;
        endcase
    endfunction

    // Moore controls for the state being entered; opcode is already in IR whenever it matters.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.retire    = 1'b1;
            end
            JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            JALR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            UPPER: begin
                c.alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b010;
            end
            TRAP:    c.trap = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = next_state(cur, run, opcode, mem_ready, wait_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= IDLE;
            ctrl_q   <= '0;
            wait_cnt <= 8'd0;
        end else begin
            cur    <= nxt;
            ctrl_q <= ctrl_for(nxt, opcode);
            // Counts only while staying in a memory state; entry and completion both clear it.
            if (nxt == cur && (cur == FETCH || cur == MEMRD || cur == MEMWR))
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign result_src = ctrl_q.result_src;
    assign trap       = ctrl_q.trap;
    assign state      = cur;

    // Write strobes that depend on same-cycle handshake or comparator inputs stay combinational.
    assign ir_write = (cur == FETCH) && mem_ready;
    assign pc_write = ctrl_q.pc_write || ((cur == FETCH) && mem_ready)
                      || ((cur == BRANCH) && branch_taken);
    assign retire   = ctrl_q.retire || ((cur == MEMWR) && mem_ready);
    assign imm_src  = (cur == DECODE) ? ((opcode == OP_JAL) ? 3'b110 : 3'b101) : ctrl_q.imm_src;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a per-instruction reference model expands each
// instruction into its expected cycle sequence; a negedge monitor compares every cycle.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 15;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6,  S_EXECR = 4'd7;
    localparam logic [3:0] S_EXECI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11;
    localparam logic [3:0] S_JALR = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd15;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] a, b, op, res;
        logic [2:0] imm;
        logic       retire, trap;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n, run, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retire, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;

    obs_t o_now;
    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    bit   idle = 1'b1;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    assign o_now = {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_op, result_src, imm_src, retire, trap};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs for one cycle, straight from the per-state control table.
    function automatic obs_t exp_of(input logic [3:0] st, input logic [6:0] op,
                                    input logic mr, input logic bt);
        obs_t e;
        e = '0;
        e.st = st;
        case (st)
            S_FETCH:  begin e.mem_req = 1; e.b = 2; e.res = 2; e.ir_write = mr; e.pc_write = mr; end
            S_DECODE: begin e.a = 1; e.b = 1; e.imm = (op == OP_JAL) ? 3'b110 : 3'b101; end
            S_MEMADR: begin e.a = 2; e.b = 1; e.imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
            S_MEMRD:  begin e.mem_req = 1; e.adr_src = 1; end
            S_MEMWB:  begin e.res = 1; e.reg_write = 1; e.retire = 1; end
            S_MEMWR:  begin e.mem_req = 1; e.mem_we = 1; e.adr_src = 1; e.retire = mr; end
            S_EXECR:  begin e.a = 2; e.op = 2; end
            S_EXECI:  begin e.a = 2; e.b = 1; e.op = 2; end
            S_ALUWB:  begin e.reg_write = 1; e.retire = 1; end
            S_BRANCH: begin e.a = 2; e.op = 1; e.pc_write = bt; e.retire = 1; end
            S_JAL:    begin e.pc_write = 1; e.a = 1; e.b = 2; end
            S_JALR:   begin e.a = 2; e.b = 1; end
            S_UPPER:  begin e.a = (op == OP_LUI) ? 2'd3 : 2'd1; e.b = 1; e.imm = 3'b010; end
            S_TRAP:   e.trap = 1;
            default:  e.st = st;
        endcase
        return e;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BR, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUIPC};
    endfunction

    // One clock of stimulus: drive inputs for the cycle whose state should be st, queue expectation.
    task automatic cyc(input logic [3:0] st, input logic r, input logic mr, input logic bt,
                       input logic [6:0] op);
        @(posedge clk);
        #1;
        run = r; mem_ready = mr; branch_taken = bt; opcode = op;
        expq.push_back(exp_of(st, op, mr, bt));
        ncyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_now !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", o_now, 23'h0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        run = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        idle = 1'b1;
    endtask

    task automatic trap_tail(input logic [6:0] op);
        repeat (3) cyc(S_TRAP, rb(), rb(), rb(), op);
        do_reset();
    endtask

    task automatic enter(input logic [6:0] op);
        if (idle) begin
            repeat ($urandom_range(0, 2)) cyc(S_IDLE, 1'b0, rb(), rb(), op);
            cyc(S_IDLE, 1'b1, rb(), rb(), op);
            idle = 1'b0;
        end
    endtask

    // lat = not-ready cycles before mem_ready; lat >= TO means the access times out.
    task automatic mem_phase(input logic [3:0] st, input int lat, input logic [6:0] op,
                             input bit is_end, input logic r_end, output bit trapped);
        int n;
        trapped = 1'b0;
        n = (lat < TO) ? lat : TO;
        for (int i = 0; i < n; i++) cyc(st, rb(), 1'b0, rb(), op);
        if (lat >= TO) begin
            trapped = 1'b1;
            trap_tail(op);
        end else begin
            cyc(st, is_end ? r_end : rb(), 1'b1, rb(), op);
        end
    endtask

    task automatic do_instr(input logic [6:0] op, input int lf, input int lm, input logic btv,
                            input logic r_end);
        bit tr;
        enter(op);
        mem_phase(S_FETCH, lf, op, 1'b0, 1'b0, tr);
        if (tr) return;
        cyc(S_DECODE, rb(), rb(), rb(), op);
        case (op)
            OP_LOAD: begin
                cyc(S_MEMADR, rb(), rb(), rb(), op);
                mem_phase(S_MEMRD, lm, op, 1'b0, 1'b0, tr);
                if (tr) return;
                cyc(S_MEMWB, r_end, rb(), rb(), op);
            end
            OP_STORE: begin
                cyc(S_MEMADR, rb(), rb(), rb(), op);
                mem_phase(S_MEMWR, lm, op, 1'b1, r_end, tr);
                if (tr) return;
            end
            OP_RTYPE: begin cyc(S_EXECR, rb(), rb(), rb(), op); cyc(S_ALUWB, r_end, rb(), rb(), op); end
            OP_ITYPE: begin cyc(S_EXECI, rb(), rb(), rb(), op); cyc(S_ALUWB, r_end, rb(), rb(), op); end
            OP_BR:    cyc(S_BRANCH, r_end, rb(), btv, op);
            OP_JAL:   begin cyc(S_JAL, rb(), rb(), rb(), op); cyc(S_ALUWB, r_end, rb(), rb(), op); end
            OP_JALR: begin
                cyc(S_JALR, rb(), rb(), rb(), op);
                cyc(S_JAL, rb(), rb(), rb(), op);
                cyc(S_ALUWB, r_end, rb(), rb(), op);
            end
            OP_LUI, OP_AUIPC: begin
                cyc(S_UPPER, rb(), rb(), rb(), op);
                cyc(S_ALUWB, r_end, rb(), rb(), op);
            end
            default: begin
                trap_tail(op);
                return;
            end
        endcase
        if (!r_end) idle = 1'b1;
    endtask

    // Monitor: every cycle that has a queued expectation is compared on the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            obs_t e;
            e = expq.pop_front();
            checks++;
            if (o_now !== e) begin
                errors++;
                $display("FAIL cycle_state%0d got=%h want=%h (at %0t)", e.st, o_now, e, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d cycles", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal [9];
        logic [6:0] op;
        legal = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
        #1;
        checks++;
        if (o_now !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", o_now, 23'h0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_instr(OP_ITYPE, 0, 0, 1'b0, 1'b1);
        do_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
        do_instr(OP_BR, 0, 0, 1'b0, 1'b1);
        do_instr(OP_BR, 0, 0, 1'b1, 1'b1);
        do_instr(OP_JALR, 0, 0, 1'b0, 1'b1);
        do_instr(OP_JAL, 1, 0, 1'b0, 1'b1);
        do_instr(OP_LUI, 0, 0, 1'b0, 1'b1);
        do_instr(OP_AUIPC, 0, 0, 1'b0, 1'b1);
        do_instr(OP_STORE, 2, 2, 1'b0, 1'b1);
        do_instr(OP_RTYPE, 0, 0, 1'b0, 1'b0);
        do_instr(OP_ITYPE, TO - 1, 0, 1'b0, 1'b1);
        do_instr(OP_STORE, 0, TO - 1, 1'b0, 1'b1);
        do_instr(7'b0000000, 0, 0, 1'b0, 1'b1);
        do_instr(OP_ITYPE, TO, 0, 1'b0, 1'b1);
        do_instr(OP_LOAD, 0, TO, 1'b0, 1'b1);
        do_instr(OP_STORE, 0, TO + 3, 1'b0, 1'b1);

        // Reset asserted while a store is waiting on memory.
        enter(OP_STORE);
        cyc(S_FETCH, rb(), 1'b1, rb(), OP_STORE);
        cyc(S_DECODE, rb(), rb(), rb(), OP_STORE);
        cyc(S_MEMADR, rb(), rb(), rb(), OP_STORE);
        cyc(S_MEMWR, rb(), 1'b0, rb(), OP_STORE);
        do_reset();

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = legal[$urandom_range(0, 8)];
            end
            do_instr(op, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), rb(),
                     ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
